// File: rtl/seven_seg_scanner.sv
// Time-multiplexed four-digit seven-segment scanner with double-buffered data,
// PWM brightness, leading-zero suppression and per-slot anti-ghost dead cycle.
module seven_seg_scanner #(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_i,
  input  logic [3:0]  dp_i,
  input  logic        load_i,
  input  logic [15:0] div_i,
  input  logic [3:0]  bright_i,
  input  logic        lz_en_i,
  input  logic        blank_i,
  output logic [7:0]  seven_seg,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  logic [15:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  pwm_cnt_q, pwm_cnt_d;
  logic        pending_q, pending_d;
  logic [15:0] shadow_dig_q, shadow_dig_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [15:0] active_dig_q, active_dig_d;
  logic [3:0]  active_dp_q, active_dp_d;
  logic        wrap_q, wrap_d;
  logic [7:0]  seven_seg_q, seven_seg_d;
  logic [3:0]  digit_en_q, digit_en_d;
  logic        frame_done_q, frame_done_d;

  logic [15:0] div_eff;
  logic        slot_last;
  logic        boundary;
  logic [3:0]  nibble;
  logic        dp_bit;
  logic        lz_hide;
  logic        en_on;
  logic [7:0]  seg_raw;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: hex_decode = 7'h3F;
      4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;
      4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;
      4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;
      4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;
      4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    div_eff   = (div_i < 16'd2) ? 16'd2 : div_i;
    // div_i is sampled live, so a shrinking divider ends the slot immediately.
    slot_last = (slot_cnt_q >= (div_eff - 16'd1));
    boundary  = slot_last && (idx_q == 2'd3);

    slot_cnt_d = slot_last ? 16'd0 : slot_cnt_q + 16'd1;
    idx_d      = slot_last ? idx_q + 2'd1 : idx_q;
    pwm_cnt_d  = pwm_cnt_q + 4'd1;
    wrap_d     = boundary;

    shadow_dig_d = load_i ? digits_i : shadow_dig_q;
    shadow_dp_d  = load_i ? dp_i : shadow_dp_q;
    // A load on the boundary cycle keeps pending set for the following frame.
    pending_d    = load_i | (pending_q & ~boundary);
    active_dig_d = (boundary && pending_q) ? shadow_dig_q : active_dig_q;
    active_dp_d  = (boundary && pending_q) ? shadow_dp_q : active_dp_q;

    nibble  = 4'h0;
    lz_hide = 1'b0;
    case (idx_q)
      2'd0: nibble = active_dig_q[3:0];
      2'd1: begin
        nibble  = active_dig_q[7:4];
        lz_hide = (active_dig_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble  = active_dig_q[11:8];
        lz_hide = (active_dig_q[15:8] == 8'h00);
      end
      default: begin
        nibble  = active_dig_q[15:12];
        lz_hide = (active_dig_q[15:12] == 4'h0);
      end
    endcase
    lz_hide = lz_hide & lz_en_i;
    dp_bit  = active_dp_q[idx_q];

    seg_raw = lz_hide ? 8'h00 : {dp_bit, hex_decode(nibble)};
    en_on   = !blank_i && (slot_cnt_q != 16'd0) && (pwm_cnt_q <= bright_i);

    seven_seg_d  = (blank_i ? 8'h00 : seg_raw) ^ {8{SEG_ACTIVE_LOW}};
    digit_en_d   = (en_on ? (4'b0001 << idx_q) : 4'b0000) ^ {4{DIG_ACTIVE_LOW}};
    frame_done_d = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q   <= 16'd0;
      idx_q        <= 2'd0;
      pwm_cnt_q    <= 4'd0;
      pending_q    <= 1'b0;
      shadow_dig_q <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      active_dig_q <= 16'h0000;
      active_dp_q  <= 4'h0;
      wrap_q       <= 1'b0;
      seven_seg_q  <= {8{SEG_ACTIVE_LOW}};
      digit_en_q   <= {4{DIG_ACTIVE_LOW}};
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      pwm_cnt_q    <= pwm_cnt_d;
      pending_q    <= pending_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      active_dig_q <= active_dig_d;
      active_dp_q  <= active_dp_d;
      wrap_q       <= wrap_d;
      seven_seg_q  <= seven_seg_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seven_seg  = seven_seg_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: table-driven display vectors plus
// directed sequences for reset, load timing, PWM, divider floor and blanking.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic [15:0] div_i;
  logic [3:0]  bright_i;
  logic        lz_en_i;
  logic        blank_i;
  logic [7:0]  seven_seg;
  logic [3:0]  digit_en;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  seven_seg_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .digits_i   (digits_i),
    .dp_i       (dp_i),
    .load_i     (load_i),
    .div_i      (div_i),
    .bright_i   (bright_i),
    .lz_en_i    (lz_en_i),
    .blank_i    (blank_i),
    .seven_seg  (seven_seg),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     dig;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][7:0] exp_seg;  // exp_seg[n] = expected segments of digit n
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_pulse(input logic [15:0] d, input logic [3:0] p);
    digits_i = d;
    dp_i     = p;
    load_i   = 1'b1;
    step();
    load_i   = 1'b0;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 400);
    if (!frame_done) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_timeout: got no frame_done expected pulse within %0d cycles", n);
    end
  endtask

  // Called on the frame_done cycle (offset 0); returns at offset 15 (div = 4).
  task automatic check_frame(input string tag, input logic [3:0][7:0] e);
    logic [3:0] oh;
    for (int o = 0; o < 16; o++) begin
      if (o > 0) step();
      oh = 4'b0001 << (o / 4);
      if (o % 4 == 0) chk({tag, "_dead_en"}, {12'h0, digit_en}, 16'h0000);
      if (o % 4 == 1) begin
        chk({tag, "_en"}, {12'h0, digit_en}, {12'h0, oh});
        chk({tag, "_seg"}, {8'h0, seven_seg}, {8'h0, e[o / 4]});
      end
    end
  endtask

  // Cycle-by-cycle check straight after reset release; expected pattern from
  // the slot/pwm definitions with all-zero display data.
  task automatic run_check(input string tag, input int d, input int br, input int ncyc,
                           input int exp_act);
    int         mism;
    int         act;
    int         t;
    logic       on;
    logic [3:0] e_en;
    logic       e_fd;
    mism = 0;
    act  = 0;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      t    = k - 1;
      on   = ((t % d) != 0) && ((t % 16) <= br);
      e_en = on ? (4'b0001 << ((t / d) % 4)) : 4'b0000;
      e_fd = (t > 0) && ((t % (4 * d)) == 0);
      if (digit_en !== e_en || frame_done !== e_fd || seven_seg !== 8'h3F) mism++;
      if (digit_en != 4'h0) act++;
    end
    chk({tag, "_pattern_mismatches"}, mism[15:0], 16'd0);
    chk({tag, "_active_cycles"}, act[15:0], exp_act[15:0]);
  endtask

  initial begin
    int n;
    int seen77;
    int bad;
    int fd_cnt;

    tbl[0] = '{16'h1234, 4'b0001, 1'b0, {8'h06, 8'h5B, 8'h4F, 8'hE6}};
    tbl[1] = '{16'h0070, 4'b0000, 1'b1, {8'h00, 8'h00, 8'h07, 8'h3F}};
    tbl[2] = '{16'h0000, 4'b0000, 1'b1, {8'h00, 8'h00, 8'h00, 8'h3F}};
    tbl[3] = '{16'h89AB, 4'b1010, 1'b0, {8'hFF, 8'h6F, 8'hF7, 8'h7C}};
    tbl[4] = '{16'hCDEF, 4'b0000, 1'b0, {8'h39, 8'h5E, 8'h79, 8'h71}};
    tbl[5] = '{16'h5067, 4'b0100, 1'b1, {8'h6D, 8'hBF, 8'h7D, 8'h07}};
    tbl[6] = '{16'h0005, 4'b1000, 1'b1, {8'h00, 8'h00, 8'h00, 8'h6D}};

    rst = 1'b1; digits_i = 16'h0; dp_i = 4'h0; load_i = 1'b0;
    div_i = 16'd4; bright_i = 4'd15; lz_en_i = 1'b0; blank_i = 1'b0;

    // Reset state, then first post-reset frame
    repeat (3) step();
    chk("rst_seg", {8'h0, seven_seg}, 16'h0000);
    chk("rst_en", {12'h0, digit_en}, 16'h0000);
    chk("rst_fd", {15'h0, frame_done}, 16'h0000);
    rst = 1'b0;
    step();
    chk("post_rst_dead_en", {12'h0, digit_en}, 16'h0000);
    chk("post_rst_seg", {8'h0, seven_seg}, 16'h003F);
    step();
    chk("post_rst_first_en", {12'h0, digit_en}, 16'h0001);
    wait_frame(n);
    chk("first_frame_done_delay", n[15:0], 16'd15);
    wait_frame(n);
    chk("frame_period", n[15:0], 16'd16);

    // Table: load mid-frame, expect it on the following frame
    for (int i = 0; i < 7; i++) begin
      lz_en_i = tbl[i].lz;
      wait_frame(n);
      load_pulse(tbl[i].dig, tbl[i].dp);
      wait_frame(n);
      check_frame($sformatf("vec%0d", i), tbl[i].exp_seg);
    end

    // Latest of two mid-frame loads wins; current frame untouched
    lz_en_i = 1'b0;
    wait_frame(n);
    step(); step();
    load_pulse(16'hAAAA, 4'h0);
    step();
    load_pulse(16'h5555, 4'h0);
    seen77 = 0;
    for (int o = 5; o < 15; o++) begin
      step();
      if (digit_en != 4'h0 && seven_seg[6:0] == 7'h77) seen77++;
    end
    chk("double_load_early_77", seen77[15:0], 16'd0);
    wait_frame(n);
    chk("double_load_boundary_delay", n[15:0], 16'd1);
    check_frame("double_load", {8'h6D, 8'h6D, 8'h6D, 8'h6D});

    // Load on the exact boundary cycle lands one frame later
    wait_frame(n);
    step(); step();
    load_pulse(16'h1111, 4'h0);
    repeat (11) step();
    load_pulse(16'h2222, 4'h0);
    wait_frame(n);
    check_frame("bnd_prev_shadow", {8'h06, 8'h06, 8'h06, 8'h06});
    wait_frame(n);
    check_frame("bnd_new_value", {8'h5B, 8'h5B, 8'h5B, 8'h5B});

    // Reset mid-frame with pending data, then PWM pattern at div 64 / bright 3
    div_i = 16'd64; bright_i = 4'd3;
    step(); step(); step();
    load_pulse(16'h9999, 4'hF);
    step(); step();
    rst = 1'b1;
    step();
    chk("midrst_seg", {8'h0, seven_seg}, 16'h0000);
    chk("midrst_en", {12'h0, digit_en}, 16'h0000);
    chk("midrst_fd", {15'h0, frame_done}, 16'h0000);
    rst = 1'b0;
    run_check("pwm64", 64, 3, 512, 120);

    // div 0 floors to 2
    div_i = 16'd0; bright_i = 4'd15;
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_check("div0", 2, 15, 32, 16);

    // Blanking forces outputs off while counters keep running
    blank_i = 1'b1;
    step();
    bad = 0;
    fd_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (digit_en != 4'h0 || seven_seg != 8'h00) bad++;
      if (frame_done) fd_cnt++;
      step();
    end
    chk("blank_outputs_on", bad[15:0], 16'd0);
    chk("blank_frame_done_cnt", fd_cnt[15:0], 16'd2);
    blank_i = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
